lsu_controller: RTL
===================

Name: lsu_controller

Overview:
Load/store sequencer between the decode-driven MEM stage and the data bus. Takes the decoded memory controls (mem_read, mem_write, mem_byte, mem_halfword, mem_unsigned) plus effective address and store data, and runs one Wishbone-style classic bus cycle. It stalls the pipeline until the access resolves. Generates byte-lane selects, store-data replication and load extraction/extension, and flags misaligned accesses and bus errors/timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUS without ack/err before the access is aborted as a bus error (range 2..255).

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  asynchronous, active-high reset
mem_read_i  input  1  load request from decode (held stable while stall_o=1)
mem_write_i  input  1  store request (never asserted together with mem_read_i)
mem_byte_i  input  1  byte access
mem_halfword_i  input  1  halfword access; neither byte nor halfword means word
mem_unsigned_i  input  1  zero-extend loads
kill_i  input  1  flush of the MEM-stage instruction
addr_i  input  32  effective address from ALU
wdata_i  input  32  store data (rs2)
stall_o  output  1  hold pipeline
rdata_o  output  32  extended load result
rdata_valid_o  output  1  load result valid (1-cycle pulse)
misaligned_o  output  1  misaligned exception (1-cycle pulse)
bus_err_o  output  1  bus error/timeout exception (1-cycle pulse)
dbus_addr_o  output  32  word-aligned bus address {addr[31:2],2'b00}
dbus_dat_o  output  32  replicated store data
dbus_sel_o  output  4  byte-lane select
dbus_we_o  output  1  write enable
dbus_cyc_o  output  1  bus cycle
dbus_stb_o  output  1  strobe (equals dbus_cyc_o)
dbus_dat_i  input  32  read data
dbus_ack_i  input  1  slave acknowledge
dbus_err_i  input  1  slave error

Behaviour:
- req = (mem_read_i | mem_write_i) & ~kill_i. States: IDLE, BUS, RESP, EXC.
- Reset (async): state IDLE. All outputs 0. dbus_cyc_o/stb_o drop immediately, even mid-cycle. Timeout counter 0.
- stall_o is combinational: (IDLE & req) | BUS. It is 0 in RESP and EXC, and the pipeline advances at the end of those cycles.
- IDLE:
  - A misaligned req goes to EXC with no bus cycle. Misaligned means word with addr[1:0]!=0, or halfword with addr[0]!=0.
  - An aligned req goes to BUS. On the same edge, register dbus_addr/dat/sel/we, set cyc=stb=1, clear the counter and latch width/unsigned/addr[1:0].
- dbus_sel_o:
  - byte: 4'b0001<<addr[1:0]
  - halfword: addr[1] ? 1100 : 0011
  - word: 1111
- dbus_dat_o:
  - byte: {4{wdata[7:0]}}
  - halfword: {2{wdata[15:0]}}
  - word: wdata
- BUS: the counter increments each cycle. Priority when events coincide is ack > err > timeout.
  - ack: drop cyc/stb, go to RESP. For loads, register the extracted lane into rdata_o, sign- or zero-extended by mem_unsigned.
  - err: drop cyc/stb, go to EXC with bus_err.
  - Timeout (counter==TIMEOUT_CYCLES-1, no ack/err): same as err.
- RESP: rdata_valid_o=1 for loads only; stores produce no pulse. Unconditionally returns to IDLE; the req still present this cycle belongs to the same instruction and is ignored.
- EXC: misaligned_o or bus_err_o=1 for one cycle, then IDLE.
- kill_i while in BUS: the bus cycle is not aborted. A sticky killed flag is set. On completion the block goes to IDLE directly with no valid/exception pulse, and rdata_o is not updated. stall_o stays 1 until completion.
- kill_i in RESP/EXC: pulses are suppressed (gated by ~kill_i).
- Latency with a zero-wait slave: req seen in cycle 0, cyc in cycle 1, ack in cycle 1, RESP in cycle 2. That is 2 stall cycles; each wait state adds one.
- rdata_o holds its last value outside RESP.

Test Plan:
- lb addr 0x1003, dbus_dat_i=0x80123456, ack after 0 waits -> sel=1000, cyc high 1 cycle, rdata_o=0xFFFFFF80 with rdata_valid 1 cycle, stall_o high exactly 2 cycles.
- lhu addr 0x2002, dbus_dat_i=0xBEEF1234, 3 wait states -> sel=1100, rdata_o=0x0000BEEF, stall_o high 5 cycles.
- sb addr 0x1001, wdata=0x000000AB -> dbus_dat_o=0xABABABAB, sel=0010, we=1, no rdata_valid pulse. sw addr 0x40 wdata 0x12345678 -> sel=1111.
- lw addr 0x1002 -> no cyc ever asserted, misaligned_o pulse in the cycle after request, stall_o 1 cycle. Same for lh addr 0x1001.
- TIMEOUT_CYCLES=4, no ack -> cyc high 4 cycles, then bus_err_o pulse. dbus_err_i in wait cycle 1 -> bus_err_o next cycle.
- kill_i in BUS then ack -> no pulses, rdata_o unchanged. rst_i mid-BUS -> cyc/stb/stall low immediately; first request after reset completes normally.

Source files
------------

// File: rtl/lsu_controller.sv
// Load/store sequencer: one classic bus cycle per MEM-stage access. Latency is 2 stall cycles with a zero-wait slave, plus 1 per wait state.
// Backpressure: stall_o holds the pipeline until ack, err or timeout. Lane select, store replication and load extension are done here.
module lsu_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        mem_byte_i,
  input  logic        mem_halfword_i,
  input  logic        mem_unsigned_i,
  input  logic        kill_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_dat_o,
  output logic [3:0]  dbus_sel_o,
  output logic        dbus_we_o,
  output logic        dbus_cyc_o,
  output logic        dbus_stb_o,
  input  logic [31:0] dbus_dat_i,
  input  logic        dbus_ack_i,
  input  logic        dbus_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP, EXC} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        req, misal, timeout, bus_fail, is_killed;
  logic [7:0]  cnt;
  logic        killed_q, exc_mis;
  logic        lat_load, lat_byte, lat_half, lat_uns;
  logic [1:0]  lat_lo;
  logic [3:0]  sel_nxt;
  logic [31:0] wdata_rep, lane, load_ext;
  logic [15:0] hw;

  assign req       = (mem_read_i | mem_write_i) & ~kill_i;
  assign misal     = mem_byte_i     ? 1'b0 :
                     mem_halfword_i ? addr_i[0] : (addr_i[1:0] != 2'b00);
  assign timeout   = (cnt == TO_LAST);
  assign bus_fail  = dbus_err_i | timeout;
  assign is_killed = killed_q | kill_i;
  assign dbus_stb_o = dbus_cyc_o;

  always_comb begin
    sel_nxt   = 4'b1111;
    wdata_rep = wdata_i;
    if (mem_byte_i) begin
      sel_nxt   = 4'b0001 << addr_i[1:0];
      wdata_rep = {4{wdata_i[7:0]}};
    end else if (mem_halfword_i) begin
      sel_nxt   = addr_i[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata_i[15:0]}};
    end
  end

  always_comb begin
    lane     = dbus_dat_i >> {lat_lo, 3'b000};
    hw       = lat_lo[1] ? dbus_dat_i[31:16] : dbus_dat_i[15:0];
    load_ext = dbus_dat_i;
    if (lat_byte)
      load_ext = {{24{~lat_uns & lane[7]}}, lane[7:0]};
    else if (lat_half)
      load_ext = {{16{~lat_uns & hw[15]}}, hw};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // A killed access still finishes its bus cycle but retires silently to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = misal ? EXC : BUS;
      BUS: begin
        if (dbus_ack_i)    state_nxt = is_killed ? IDLE : RESP;
        else if (bus_fail) state_nxt = is_killed ? IDLE : EXC;
      end
      RESP:    state_nxt = IDLE;
      EXC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_o       = ~rst_i & (((state == IDLE) & req) | (state == BUS));
    rdata_valid_o = (state == RESP) & lat_load & ~kill_i;
    misaligned_o  = (state == EXC) & exc_mis & ~kill_i;
    bus_err_o     = (state == EXC) & ~exc_mis & ~kill_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dbus_addr_o <= '0;
      dbus_dat_o  <= '0;
      dbus_sel_o  <= '0;
      dbus_we_o   <= 1'b0;
      dbus_cyc_o  <= 1'b0;
      rdata_o     <= '0;
      cnt         <= '0;
      killed_q    <= 1'b0;
      exc_mis     <= 1'b0;
      lat_load    <= 1'b0;
      lat_byte    <= 1'b0;
      lat_half    <= 1'b0;
      lat_uns     <= 1'b0;
      lat_lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (misal) begin
              exc_mis <= 1'b1;
            end else begin
              dbus_addr_o <= {addr_i[31:2], 2'b00};
              dbus_dat_o  <= wdata_rep;
              dbus_sel_o  <= sel_nxt;
              dbus_we_o   <= mem_write_i;
              dbus_cyc_o  <= 1'b1;
              cnt         <= '0;
              killed_q    <= 1'b0;
              lat_load    <= mem_read_i;
              lat_byte    <= mem_byte_i;
              lat_half    <= mem_halfword_i & ~mem_byte_i;
              lat_uns     <= mem_unsigned_i;
              lat_lo      <= addr_i[1:0];
            end
          end
        end
        BUS: begin
          cnt <= cnt + 8'd1;
          if (kill_i) killed_q <= 1'b1;
          if (dbus_ack_i) begin
            dbus_cyc_o <= 1'b0;
            if (lat_load & ~is_killed) rdata_o <= load_ext;
          end else if (bus_fail) begin
            dbus_cyc_o <= 1'b0;
            exc_mis    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
